// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// FSM encoding is one-hot; row/column indices pack directly into the key code.
package keypad_pkg;

   localparam int unsigned NUM_ROWS   = 4;
   localparam int unsigned NUM_COLS   = 4;
   localparam int unsigned KEY_CODE_W = 4;
   localparam int unsigned ROW_IDX_W  = 2;
   localparam int unsigned COL_IDX_W  = 2;

   typedef enum logic [2:0] {
      StScan     = 3'b001,
      StDebounce = 3'b010,
      StPressed  = 3'b100
   } state_e;

   // Active-low one-hot row drive pattern for a given row index.
   function automatic logic [NUM_ROWS-1:0] row_drive(input logic [ROW_IDX_W-1:0] idx);
      return ~(NUM_ROWS'(1) << idx);
   endfunction

   // Index of the lowest column pulled low; lowest column wins on multiple closures.
   function automatic logic [COL_IDX_W-1:0] lowest_zero(input logic [NUM_COLS-1:0] cols);
      logic [COL_IDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_COLS - 1; i >= 0; i--) begin
         if (!cols[i]) idx = COL_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer, resets to all-ones so pulled-up inputs read as idle.
module sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '1;
         q      <= '1;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks active-low rows, debounces one key at a time and
// emits press/release pulses with the key code.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned ROW_CYCLES = 50_000,
   parameter int unsigned DEB_CYCLES = 500_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_COLS-1:0]   col_in,
   output logic [NUM_ROWS-1:0]   row_out,
   output logic                  key_valid,
   output logic                  key_up,
   output logic                  key_down,
   output logic [KEY_CODE_W-1:0] key_code
);

   localparam int unsigned ROW_CNT_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
   localparam int unsigned DEB_CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [ROW_CNT_W-1:0] ROW_LAST = ROW_CNT_W'(ROW_CYCLES - 1);
   localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

   state_e               state_q;
   logic [ROW_IDX_W-1:0] row_idx_q;
   logic [COL_IDX_W-1:0] col_idx_q;
   logic [ROW_CNT_W-1:0] row_cnt_q;
   logic [DEB_CNT_W-1:0] deb_cnt_q;
   logic [DEB_CNT_W-1:0] rel_cnt_q;
   logic [NUM_COLS-1:0]  col_sync;
   logic [ROW_IDX_W-1:0] row_next;

   sync2 #(
      .WIDTH (NUM_COLS)
   ) u_col_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (col_in),
      .q     (col_sync)
   );

   assign row_next = row_idx_q + ROW_IDX_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StScan;
         row_idx_q <= '0;
         col_idx_q <= '0;
         row_cnt_q <= '0;
         deb_cnt_q <= '0;
         rel_cnt_q <= '0;
         row_out   <= row_drive('0);
         key_valid <= 1'b0;
         key_up    <= 1'b0;
         key_down  <= 1'b0;
         key_code  <= '0;
      end else begin
         key_valid <= 1'b0;
         key_up    <= 1'b0;
         unique case (state_q)
            StScan: begin
               if (row_cnt_q == ROW_LAST) begin
                  row_cnt_q <= '0;
                  if (col_sync == '1) begin
                     row_idx_q <= row_next;
                     row_out   <= row_drive(row_next);
                  end else begin
                     col_idx_q <= lowest_zero(col_sync);
                     deb_cnt_q <= '0;
                     state_q   <= StDebounce;
                  end
               end else begin
                  row_cnt_q <= row_cnt_q + ROW_CNT_W'(1);
               end
            end
            StDebounce: begin
               if (col_sync[col_idx_q]) begin
                  // Bounce: abandon this key and move on to the next row.
                  state_q   <= StScan;
                  row_idx_q <= row_next;
                  row_out   <= row_drive(row_next);
                  row_cnt_q <= '0;
                  deb_cnt_q <= '0;
               end else if (deb_cnt_q == DEB_LAST) begin
                  state_q   <= StPressed;
                  deb_cnt_q <= '0;
                  rel_cnt_q <= '0;
                  key_code  <= {row_idx_q, col_idx_q};
                  key_down  <= 1'b1;
                  key_valid <= 1'b1;
               end else begin
                  deb_cnt_q <= deb_cnt_q + DEB_CNT_W'(1);
               end
            end
            StPressed: begin
               if (!col_sync[col_idx_q]) begin
                  rel_cnt_q <= '0;
               end else if (rel_cnt_q == DEB_LAST) begin
                  state_q   <= StScan;
                  rel_cnt_q <= '0;
                  row_idx_q <= row_next;
                  row_out   <= row_drive(row_next);
                  row_cnt_q <= '0;
                  key_down  <= 1'b0;
                  key_up    <= 1'b1;
               end else begin
                  rel_cnt_q <= rel_cnt_q + DEB_CNT_W'(1);
               end
            end
            default: begin
               state_q   <= StScan;
               row_idx_q <= '0;
               col_idx_q <= '0;
               row_cnt_q <= '0;
               deb_cnt_q <= '0;
               rel_cnt_q <= '0;
               row_out   <= row_drive('0);
               key_down  <= 1'b0;
               key_code  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a switch-matrix keypad model.
module tb_keypad_scan;

   logic        clk;
   logic        rst_n;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic        key_valid;
   logic        key_up;
   logic        key_down;
   logic [3:0]  key_code;
   logic [15:0] sw;

   int vectors = 0;
   int miscompares = 0;
   int valid_cnt = 0;
   int up_cnt = 0;
   int base_valid;
   int base_up;
   bit found;

   keypad_scan #(
      .ROW_CYCLES (8),
      .DEB_CYCLES (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .col_in    (col_in),
      .row_out   (row_out),
      .key_valid (key_valid),
      .key_up    (key_up),
      .key_down  (key_down),
      .key_code  (key_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Column c is pulled low when the driven row has a closed switch at c.
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row_out[r] && sw[r*4+c]) col_in[c] = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (key_valid) valid_cnt++;
      if (key_up) up_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         step(1);
         if (key_valid) ok = 1'b1;
      end
   endtask

   initial begin
      sw    = '0;
      rst_n = 1'b0;
      step(3);
      // 1: reset values and idle row walk
      chk("rst_row_out", 32'(row_out), 32'hE);
      chk("rst_key_valid", 32'(key_valid), 32'h0);
      chk("rst_key_up", 32'(key_up), 32'h0);
      chk("rst_key_down", 32'(key_down), 32'h0);
      chk("rst_key_code", 32'(key_code), 32'h0);
      rst_n = 1'b1;
      step(7);
      chk("scan_row0_hold", 32'(row_out), 32'hE);
      step(1);
      chk("scan_row1", 32'(row_out), 32'hD);
      step(8);
      chk("scan_row2", 32'(row_out), 32'hB);
      step(8);
      chk("scan_row3", 32'(row_out), 32'h7);
      step(8);
      chk("scan_wrap_row0", 32'(row_out), 32'hE);
      chk("scan_no_valid", 32'(valid_cnt), 32'd0);

      // 2: press row2/col1
      sw[2*4+1] = 1'b1;
      wait_valid(100, found);
      chk("press9_seen", 32'(found), 32'h1);
      chk("press9_code", 32'(key_code), 32'd9);
      chk("press9_down", 32'(key_down), 32'h1);
      chk("press9_row", 32'(row_out), 32'hB);
      step(1);
      chk("press9_pulse_1cyc", 32'(key_valid), 32'h0);
      step(200);
      chk("press9_frozen", 32'(row_out), 32'hB);
      chk("press9_still_down", 32'(key_down), 32'h1);
      chk("press9_one_valid", 32'(valid_cnt), 32'd1);

      // 4: release with a re-close glitch; count restarts at the re-close
      base_up = up_cnt;
      sw[2*4+1] = 1'b0;
      step(10);
      sw[2*4+1] = 1'b1;
      step(2);
      sw[2*4+1] = 1'b0;
      step(17);
      chk("rel9_not_yet", 32'(key_up), 32'h0);
      chk("rel9_no_early_up", 32'(up_cnt - base_up), 32'd0);
      step(1);
      chk("rel9_up", 32'(key_up), 32'h1);
      chk("rel9_down_low", 32'(key_down), 32'h0);
      chk("rel9_code_held", 32'(key_code), 32'd9);
      chk("rel9_row3", 32'(row_out), 32'h7);
      step(1);
      chk("rel9_up_1cyc", 32'(key_up), 32'h0);

      // 3: short closure on row3/col0 is seen, then rejected as a bounce
      base_valid = valid_cnt;
      step(3);
      sw[3*4+0] = 1'b1;
      step(5);
      sw[3*4+0] = 1'b0;
      chk("bounce_in_debounce", 32'(row_out), 32'h7);
      step(3);
      chk("bounce_next_row0", 32'(row_out), 32'hE);
      step(40);
      chk("bounce_no_valid", 32'(valid_cnt - base_valid), 32'd0);
      chk("bounce_down_low", 32'(key_down), 32'h0);

      // 5: two closures on row1, lowest column wins; release only col1
      sw[1*4+1] = 1'b1;
      sw[1*4+3] = 1'b1;
      wait_valid(100, found);
      chk("press5_seen", 32'(found), 32'h1);
      chk("press5_code", 32'(key_code), 32'd5);
      chk("press5_row", 32'(row_out), 32'hD);
      step(5);
      sw[1*4+1] = 1'b0;
      step(17);
      chk("rel5_not_yet", 32'(key_up), 32'h0);
      step(1);
      chk("rel5_up", 32'(key_up), 32'h1);
      chk("rel5_down_low", 32'(key_down), 32'h0);
      chk("rel5_row2", 32'(row_out), 32'hB);
      sw = '0;

      // 6: reset mid-debounce on row0/col2, then re-detect
      sw[0*4+2] = 1'b1;
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      base_valid = valid_cnt;
      step(18);
      chk("deb_row0_held", 32'(row_out), 32'hE);
      rst_n = 1'b0;
      #1;
      chk("midrst_row_out", 32'(row_out), 32'hE);
      chk("midrst_key_valid", 32'(key_valid), 32'h0);
      chk("midrst_key_down", 32'(key_down), 32'h0);
      chk("midrst_key_code", 32'(key_code), 32'h0);
      step(1);
      chk("midrst_no_pulse", 32'(valid_cnt - base_valid), 32'd0);
      rst_n = 1'b1;
      step(23);
      chk("redet_not_yet", 32'(key_valid), 32'h0);
      step(1);
      chk("redet_valid", 32'(key_valid), 32'h1);
      chk("redet_code", 32'(key_code), 32'd2);
      chk("redet_down", 32'(key_down), 32'h1);
      step(2);
      chk("redet_one_valid", 32'(valid_cnt - base_valid), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
